// File: rtl/itg_pkg.sv
// Shared definitions for the patch scheduler: FSM state encoding, width helper
// and the overlap/step geometry derived from the patch window parameters.
package itg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_BLANK = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int calc_adjust(input int patch_size);
    return (patch_size - 1) * 2;
  endfunction

  function automatic int calc_step(input int win, input int patch_size);
    return win - calc_adjust(patch_size);
  endfunction

  function automatic int calc_patches(input int total, input int win, input int patch_size);
    return (total - calc_adjust(patch_size)) / calc_step(win, patch_size);
  endfunction

endpackage

// File: rtl/itg_patch_sched_if.sv
// Control and frame-buffer/datapath signals of the patch scheduler, bundled
// so the scheduler (master) and its consumer (slave) share one port.
interface itg_patch_sched_if import itg_pkg::*; #(
  parameter int HEIGHT     = -1,
  parameter int WIDTH      = -1,
  parameter int W_HEIGHT   = -1,
  parameter int W_WIDTH    = -1,
  parameter int PATCH_SIZE = -1
) ();
  localparam int ADDR_W = log2(HEIGHT * WIDTH);
  localparam int VC_W   = log2(W_HEIGHT);
  localparam int HC_W   = log2(W_WIDTH);
  localparam int PY_W   = log2(HEIGHT / calc_step(W_HEIGHT, PATCH_SIZE) + 1);
  localparam int PX_W   = log2(WIDTH / calc_step(W_WIDTH, PATCH_SIZE) + 1);

  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              out_enable;
  logic [VC_W-1:0]   out_vcnt;
  logic [HC_W-1:0]   out_hcnt;
  logic [PY_W-1:0]   out_py;
  logic [PX_W-1:0]   out_px;

  modport master (
    input  start, abort,
    output busy, done, rd_en, rd_addr, out_enable, out_vcnt, out_hcnt, out_py, out_px
  );

  modport slave (
    output start, abort,
    input  busy, done, rd_en, rd_addr, out_enable, out_vcnt, out_hcnt, out_py, out_px
  );
endinterface

// File: rtl/itg_win_counter.sv
// Nested pixel/row/patch-column/patch-row counter walking every patch window
// in row-major order, with end-of-row and end-of-frame flags.
module itg_win_counter #(
  parameter int W_HEIGHT = 12,
  parameter int W_WIDTH  = 12,
  parameter int N_PY     = 2,
  parameter int N_PX     = 2,
  parameter int VC_W     = 4,
  parameter int HC_W     = 4,
  parameter int PY_W     = 2,
  parameter int PX_W     = 2
) (
  input  logic            clock,
  input  logic            n_rst,
  input  logic            clr,
  input  logic            adv,
  output logic [VC_W-1:0] vcnt,
  output logic [HC_W-1:0] hcnt,
  output logic [PY_W-1:0] py,
  output logic [PX_W-1:0] px,
  output logic            row_last,
  output logic            frame_last
);
  logic [VC_W-1:0] vcnt_reg;
  logic [HC_W-1:0] hcnt_reg;
  logic [PY_W-1:0] py_reg;
  logic [PX_W-1:0] px_reg;
  logic            win_last;
  logic            px_last;
  logic            py_last;

  assign row_last   = (hcnt_reg == HC_W'(W_WIDTH - 1));
  assign win_last   = row_last && (vcnt_reg == VC_W'(W_HEIGHT - 1));
  assign px_last    = (px_reg == PX_W'(N_PX - 1));
  assign py_last    = (py_reg == PY_W'(N_PY - 1));
  assign frame_last = win_last && px_last && py_last;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      vcnt_reg <= '0;
      hcnt_reg <= '0;
      py_reg   <= '0;
      px_reg   <= '0;
    end else if (clr) begin
      vcnt_reg <= '0;
      hcnt_reg <= '0;
      py_reg   <= '0;
      px_reg   <= '0;
    end else if (adv) begin
      if (!row_last) begin
        hcnt_reg <= hcnt_reg + 1'b1;
      end else begin
        hcnt_reg <= '0;
        if (!win_last) begin
          vcnt_reg <= vcnt_reg + 1'b1;
        end else begin
          vcnt_reg <= '0;
          // Window finished: step to the next patch, wrapping the column into the next row.
          if (!px_last) begin
            px_reg <= px_reg + 1'b1;
          end else begin
            px_reg <= '0;
            py_reg <= py_last ? '0 : py_reg + 1'b1;
          end
        end
      end
    end
  end

  assign vcnt = vcnt_reg;
  assign hcnt = hcnt_reg;
  assign py   = py_reg;
  assign px   = px_reg;
endmodule

// File: rtl/itg_patch_sched.sv
// Frame-buffer read scheduler issuing overlapping patch windows, then draining
// the datapath. Optional per-row blanking is enabled by ITGSCHED_HBLANK_EN.
module itg_patch_sched import itg_pkg::*; #(
  parameter int HEIGHT     = -1,
  parameter int WIDTH      = -1,
  parameter int W_HEIGHT   = -1,
  parameter int W_WIDTH    = -1,
  parameter int PATCH_SIZE = -1,
  parameter int DRAIN_LAT  = -1,
  parameter int HBLANK     = 0
) (
  input  logic               clock,
  input  logic               n_rst,
  itg_patch_sched_if.master  bus
);
  localparam int VSTEP  = calc_step(W_HEIGHT, PATCH_SIZE);
  localparam int HSTEP  = calc_step(W_WIDTH, PATCH_SIZE);
  localparam int N_PY   = calc_patches(HEIGHT, W_HEIGHT, PATCH_SIZE);
  localparam int N_PX   = calc_patches(WIDTH, W_WIDTH, PATCH_SIZE);
  localparam int ADDR_W = log2(HEIGHT * WIDTH);
  localparam int VC_W   = log2(W_HEIGHT);
  localparam int HC_W   = log2(W_WIDTH);
  localparam int PY_W   = log2(HEIGHT / VSTEP + 1);
  localparam int PX_W   = log2(WIDTH / HSTEP + 1);
  localparam int DR_W   = log2(DRAIN_LAT + 1);

  state_t            state_reg, state_next;
  logic [DR_W-1:0]   drain_cnt_reg;
  logic              drain_end;
  logic              blank_end;
  logic              rd_en;
  logic              row_last;
  logic              frame_last;
  logic [VC_W-1:0]   vcnt;
  logic [HC_W-1:0]   hcnt;
  logic [PY_W-1:0]   py;
  logic [PX_W-1:0]   px;
  logic [ADDR_W-1:0] row_addr;
  logic [ADDR_W-1:0] rd_addr_calc;
  logic              out_enable_reg;
  logic [VC_W-1:0]   out_vcnt_reg;
  logic [HC_W-1:0]   out_hcnt_reg;
  logic [PY_W-1:0]   out_py_reg;
  logic [PX_W-1:0]   out_px_reg;

`ifdef ITGSCHED_HBLANK_EN
  localparam bit BLANK_ON = (HBLANK > 0);
  localparam int BL_W     = log2(HBLANK + 1);
  logic [BL_W-1:0] blank_cnt_reg;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst)                      blank_cnt_reg <= '0;
    else if (state_reg == ST_BLANK)  blank_cnt_reg <= blank_cnt_reg + 1'b1;
    else                             blank_cnt_reg <= '0;
  end

  assign blank_end = (blank_cnt_reg == BL_W'(HBLANK - 1));
`else
  // Rows run back-to-back; HBLANK only matters when blanking is built in.
  localparam bit BLANK_ON = 1'b0 && (HBLANK > 0);
  assign blank_end = 1'b1;
`endif

  itg_win_counter #(
    .W_HEIGHT (W_HEIGHT),
    .W_WIDTH  (W_WIDTH),
    .N_PY     (N_PY),
    .N_PX     (N_PX),
    .VC_W     (VC_W),
    .HC_W     (HC_W),
    .PY_W     (PY_W),
    .PX_W     (PX_W)
  ) u_win (
    .clock      (clock),
    .n_rst      (n_rst),
    .clr        (state_reg == ST_IDLE),
    .adv        (rd_en),
    .vcnt       (vcnt),
    .hcnt       (hcnt),
    .py         (py),
    .px         (px),
    .row_last   (row_last),
    .frame_last (frame_last)
  );

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start && !bus.abort) state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (bus.abort)                state_next = ST_IDLE;
        else if (frame_last)          state_next = (DRAIN_LAT > 0) ? ST_DRAIN : ST_DONE;
        else if (BLANK_ON && row_last) state_next = ST_BLANK;
      end
      ST_BLANK: begin
        if (bus.abort)      state_next = ST_IDLE;
        else if (blank_end) state_next = ST_SCAN;
      end
      ST_DRAIN: begin
        if (bus.abort)      state_next = ST_IDLE;
        else if (drain_end) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // DRAIN begins the cycle the final out_enable is presented.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst)                      drain_cnt_reg <= '0;
    else if (state_reg == ST_DRAIN)  drain_cnt_reg <= drain_cnt_reg + 1'b1;
    else                             drain_cnt_reg <= '0;
  end

  assign drain_end = (drain_cnt_reg == DR_W'(DRAIN_LAT - 1));
  assign rd_en     = (state_reg == ST_SCAN);

  always_comb begin
    row_addr     = ADDR_W'(py) * ADDR_W'(VSTEP) + ADDR_W'(vcnt);
    rd_addr_calc = row_addr * ADDR_W'(WIDTH) + ADDR_W'(px) * ADDR_W'(HSTEP) + ADDR_W'(hcnt);
  end

  // Coordinates track the read one cycle later and hold between reads.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      out_enable_reg <= 1'b0;
      out_vcnt_reg   <= '0;
      out_hcnt_reg   <= '0;
      out_py_reg     <= '0;
      out_px_reg     <= '0;
    end else begin
      out_enable_reg <= rd_en;
      if (rd_en) begin
        out_vcnt_reg <= vcnt;
        out_hcnt_reg <= hcnt;
        out_py_reg   <= py;
        out_px_reg   <= px;
      end
    end
  end

  assign bus.busy       = (state_reg == ST_SCAN) || (state_reg == ST_BLANK) || (state_reg == ST_DRAIN);
  assign bus.done       = (state_reg == ST_DONE);
  assign bus.rd_en      = rd_en;
  assign bus.rd_addr    = rd_addr_calc;
  assign bus.out_enable = out_enable_reg;
  assign bus.out_vcnt   = out_vcnt_reg;
  assign bus.out_hcnt   = out_hcnt_reg;
  assign bus.out_py     = out_py_reg;
  assign bus.out_px     = out_px_reg;
endmodule

// File: tb/tb_itg_patch_sched.sv
// Scoreboard bench for itg_patch_sched: frames of expected reads are queued
// from a window-geometry model; a negedge monitor pops and compares them.
module tb_itg_patch_sched;
  localparam int HEIGHT     = 20;
  localparam int WIDTH      = 20;
  localparam int W_HEIGHT   = 12;
  localparam int W_WIDTH    = 12;
  localparam int PATCH_SIZE = 3;
  localparam int DRAIN_LAT  = 10;
  localparam int HBLANK     = 3;
`ifdef ITGSCHED_HBLANK_EN
  localparam int HB = HBLANK;
`else
  localparam int HB = 0;
`endif
  localparam int OVL       = (PATCH_SIZE - 1) * 2;
  localparam int VS        = W_HEIGHT - OVL;
  localparam int HS        = W_WIDTH - OVL;
  localparam int NPX       = (WIDTH - OVL) / HS;
  localparam int NPY       = (HEIGHT - OVL) / VS;
  localparam int WIN_PIX   = W_HEIGHT * W_WIDTH;
  localparam int FRAME_PIX = NPY * NPX * WIN_PIX;

  typedef struct {
    int cyc;
    int addr;
    int vc;
    int hc;
    int py;
    int px;
  } pix_t;

  logic clock = 1'b0;
  logic n_rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  int   exp_done = -1;
  pix_t rd_q[$];
  pix_t out_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  itg_patch_sched_if #(
    .HEIGHT(HEIGHT), .WIDTH(WIDTH), .W_HEIGHT(W_HEIGHT), .W_WIDTH(W_WIDTH), .PATCH_SIZE(PATCH_SIZE)
  ) bus ();

  itg_patch_sched #(
    .HEIGHT(HEIGHT), .WIDTH(WIDTH), .W_HEIGHT(W_HEIGHT), .W_WIDTH(W_WIDTH),
    .PATCH_SIZE(PATCH_SIZE), .DRAIN_LAT(DRAIN_LAT), .HBLANK(HBLANK)
  ) dut (
    .clock (clock),
    .n_rst (n_rst),
    .bus   (bus)
  );

  function automatic void check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int coord_code(input int vc, input int hc, input int py, input int px);
    return vc * 1000000 + hc * 10000 + py * 100 + px;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clock) begin : monitor
    pix_t e;
    pix_t last_out;
    int   act;
    bit   exp_busy;
    if (!n_rst) begin
      last_out = '{default: 0};
    end else begin
      if (bus.rd_en) begin
        if (rd_q.size() == 0) begin
          check(1'b0, "rd_en_unexpected", int'(bus.rd_addr), -1);
        end else begin
          e = rd_q.pop_front();
          check(cyc == e.cyc, "rd_cycle", cyc, e.cyc);
          check(int'(bus.rd_addr) == e.addr, "rd_addr", int'(bus.rd_addr), e.addr);
          if (e.py == 1 && e.px == 1 && e.vc == 0 && e.hc == 0)
            check(int'(bus.rd_addr) == 168, "rd_addr_p11_first", int'(bus.rd_addr), 168);
          if (e.py == 0 && e.px == 1 && e.vc == 11 && e.hc == 11)
            check(int'(bus.rd_addr) == 239, "rd_addr_p01_last", int'(bus.rd_addr), 239);
        end
      end
      act = coord_code(int'(bus.out_vcnt), int'(bus.out_hcnt), int'(bus.out_py), int'(bus.out_px));
      if (bus.out_enable) begin
        if (out_q.size() == 0) begin
          check(1'b0, "out_enable_unexpected", act, -1);
        end else begin
          e = out_q.pop_front();
          check(cyc == e.cyc + 1, "out_cycle", cyc, e.cyc + 1);
          check(act == coord_code(e.vc, e.hc, e.py, e.px), "out_coords", act,
                coord_code(e.vc, e.hc, e.py, e.px));
          last_out = e;
        end
      end else begin
        check(act == coord_code(last_out.vc, last_out.hc, last_out.py, last_out.px), "coord_hold",
              act, coord_code(last_out.vc, last_out.hc, last_out.py, last_out.px));
      end
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      check(bus.busy == exp_busy, "busy", int'(bus.busy), int'(exp_busy));
      if (bus.done || (exp_done >= 0 && cyc == exp_done))
        check(bus.done && cyc == exp_done, "done_cycle", bus.done ? cyc : -1, exp_done);
    end
  end

  task automatic check_all_zero(input string tag);
    check(bus.busy == 1'b0, {tag, "_busy"}, int'(bus.busy), 0);
    check(bus.done == 1'b0, {tag, "_done"}, int'(bus.done), 0);
    check(bus.rd_en == 1'b0, {tag, "_rd_en"}, int'(bus.rd_en), 0);
    check(bus.out_enable == 1'b0, {tag, "_out_enable"}, int'(bus.out_enable), 0);
    check(bus.rd_addr == '0, {tag, "_rd_addr"}, int'(bus.rd_addr), 0);
    check(coord_code(int'(bus.out_vcnt), int'(bus.out_hcnt), int'(bus.out_py), int'(bus.out_px)) == 0,
          {tag, "_coords"},
          coord_code(int'(bus.out_vcnt), int'(bus.out_hcnt), int'(bus.out_py), int'(bus.out_px)), 0);
  endtask

  // One frame: queue the expected reads, pulse start, then play abort/extra starts/reset.
  task automatic run_frame(input int abort_at, input bit extra_starts, input bit rst_in_drain);
    int   s, n, last, abort_c, end_c, p, w;
    pix_t e;
    repeat ($urandom_range(1, 4)) tick();
    s = cyc;
    n = (abort_at > 0) ? abort_at : FRAME_PIX;
    last = s;
    for (int j = 0; j < n; j++) begin
      p      = j / WIN_PIX;
      w      = j % WIN_PIX;
      e.py   = p / NPX;
      e.px   = p % NPX;
      e.vc   = w / W_WIDTH;
      e.hc   = w % W_WIDTH;
      e.addr = (e.py * VS + e.vc) * WIDTH + e.px * HS + e.hc;
      e.cyc  = s + 1 + j + HB * (j / W_WIDTH);
      rd_q.push_back(e);
      out_q.push_back(e);
      last = e.cyc;
    end
    busy_lo = s + 1;
    if (abort_at > 0) begin
      abort_c  = last;
      busy_hi  = last;
      exp_done = -1;
      end_c    = last + 4;
    end else begin
      abort_c  = -1;
      exp_done = last + 1 + DRAIN_LAT;
      busy_hi  = exp_done - 1;
      end_c    = exp_done + 2;
    end
    $display("frame: start_cycle=%0d reads=%0d abort_at=%0d extra_starts=%0d reset_in_drain=%0d",
             s, n, abort_at, extra_starts, rst_in_drain);
    bus.start = 1'b1;
    tick();
    while (cyc < end_c) begin
      bus.abort = (cyc == abort_c);
      bus.start = extra_starts && (cyc <= busy_hi) && ($urandom_range(0, 99) < 3);
      if (rst_in_drain && cyc == last + 4) begin
        exp_done = -1;
        busy_hi  = cyc - 1;
        #1 n_rst = 1'b0;
        #1 check_all_zero("reset_in_drain");
      end
      if (rst_in_drain && cyc == last + 6) n_rst = 1'b1;
      tick();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    n_rst = 1'b1;
    tick();

    run_frame(0, 1'b1, 1'b0);
    run_frame(300, 1'b0, 1'b0);

    // Start and abort together while idle: nothing may start.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    $display("idle: start+abort same cycle at %0d", cyc - 1);
    repeat (10) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    $display("idle: lone abort at %0d", cyc - 1);
    repeat (10) tick();

    run_frame(0, 1'b0, 1'b0);
    run_frame($urandom_range(1, FRAME_PIX - 1), 1'b1, 1'b0);
    run_frame(0, 1'b1, 1'b1);
    run_frame(0, 1'b0, 1'b0);

    repeat (5) tick();
    check(rd_q.size() == 0, "rd_queue_drained", rd_q.size(), 0);
    check(out_q.size() == 0, "out_queue_drained", out_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/itg_patch_sched.md
ITG_PATCH_SCHED -- requirements
Module: itg_patch_sched

Interface
REQ-001 Param HEIGHT, -1, full frame height in pixels.
REQ-002 Param WIDTH, -1, full frame width in pixels.
REQ-003 Param W_HEIGHT, -1, patch window height.
REQ-004 Param W_WIDTH, -1, patch window width.
REQ-005 Param PATCH_SIZE, -1, network patch size; overlap ADJUST=(PATCH_SIZE-1)*2; steps VSTEP=W_HEIGHT-ADJUST, HSTEP=W_WIDTH-ADJUST.
REQ-006 Param DRAIN_LAT, -1, datapath latency in cycles from last window pixel in to last result out.
REQ-007 Param HBLANK, 0, idle cycles after each window row; used only under ITGSCHED_HBLANK_EN.
REQ-008 clock  in  1  sole clock; all state changes on its rising edge.
REQ-009 n_rst  in  1  asynchronous, active-low reset.
REQ-010 start  in  1  one-cycle pulse; begins a frame when idle.
REQ-011 abort  in  1  synchronous cancel of the current frame.
REQ-012 busy  out  1  high from the cycle after an accepted start until done.
REQ-013 done  out  1  one-cycle pulse when the frame completes.
REQ-014 rd_en  out  1  frame-buffer read strobe.
REQ-015 rd_addr  out  log2(HEIGHT*WIDTH)  frame-buffer linear address.
REQ-016 out_enable  out  1  datapath in_enable, aligned with read data.
REQ-017 out_vcnt / out_hcnt  out  log2(W_HEIGHT) / log2(W_WIDTH)  window coordinates of current pixel.
REQ-018 out_py / out_px  out  log2(HEIGHT/VSTEP+1) / log2(WIDTH/HSTEP+1)  current patch row/column index.

Function
REQ-019 States: IDLE, SCAN, BLANK, DRAIN, DONE.
REQ-020 IDLE->SCAN on start; start is ignored in every other state.
REQ-021 SCAN: rd_en=1 each cycle; hcnt 0..W_WIDTH-1, then vcnt increments; after the last pixel of a window, px increments, wrapping to 0 with py increment.
REQ-022 Patch order is row-major; patch count (HEIGHT-ADJUST)/VSTEP x (WIDTH-ADJUST)/HSTEP; the frame shall satisfy HEIGHT=n*VSTEP+ADJUST and WIDTH=m*HSTEP+ADJUST.
REQ-023 rd_addr=(py*VSTEP+vcnt)*WIDTH+px*HSTEP+hcnt, unsigned, computed at full address width without truncation.
REQ-024 out_enable, out_vcnt, out_hcnt, out_py, out_px are registered 1 cycle after the rd_en/rd_addr they describe (1-cycle buffer read latency).
REQ-025 After the last pixel of the last patch: SCAN->DRAIN; DRAIN counts DRAIN_LAT cycles after the final out_enable, then DONE.
REQ-026 DONE lasts exactly one cycle with done=1, then IDLE; busy deasserts in the same cycle done asserts.
REQ-027 abort in SCAN/BLANK/DRAIN: next state IDLE, rd_en=0 from the next cycle, no done pulse; out_enable drops one cycle later; abort in IDLE/DONE has no effect.
REQ-028 abort and start in the same IDLE cycle: abort wins, frame not started.
REQ-029 Coordinate outputs hold their last values while out_enable=0.

Reset
REQ-030 n_rst low: state IDLE, all counters 0, busy=done=rd_en=out_enable=0, rd_addr and all coordinate outputs 0, asynchronously.
REQ-031 Reset mid-frame discards the frame; the first start after release begins at patch (0,0).

Configuration
REQ-032 With ITGSCHED_HBLANK_EN defined: after each window row, SCAN->BLANK for HBLANK cycles with rd_en=0, then SCAN; no blank after the last row of the last patch; HBLANK=0 behaves as undefined.
REQ-033 Without ITGSCHED_HBLANK_EN: BLANK state absent; rows issue back-to-back.

Structure
REQ-034 Shared package itg_pkg holds the state encoding, the log2 function, and ADJUST/VSTEP/HSTEP derivation.
REQ-035 One sub-module itg_win_counter (hcnt/vcnt/px/py nested wrap counter with last-pixel flags); FSM, address calculation and drain counter stay at top level.

Verification (HEIGHT=WIDTH=20, W_HEIGHT=W_WIDTH=12, PATCH_SIZE=3, DRAIN_LAT=10)
REQ-036 start pulse, no macro -> 4 patches, 576 rd_en cycles contiguous, done exactly 10 cycles after the last out_enable, busy high throughout.
REQ-037 Address check -> patch (1,1) pixel (0,0) rd_addr=168; patch (0,1) pixel (11,11) rd_addr=239.
REQ-038 abort at rd_en count 300 -> rd_en=0 the next cycle, IDLE, no done; subsequent start restarts at rd_addr=0.
REQ-039 start repeated while busy -> ignored, single done; start+abort same IDLE cycle -> remains IDLE.
REQ-040 ITGSCHED_HBLANK_EN, HBLANK=3 -> 3 idle cycles after each of 47 non-final rows; done 576+141+10+1 cycles after start.
REQ-041 n_rst pulse mid-DRAIN -> all outputs 0 immediately, no done pulse.
